// File: rtl/rule_scheduler.sv
// Rule scheduler: picks one enabled Murphi rule per cycle (round-robin or
// LFSR-seeded scan), drives its index to the system model, counts fires and
// flags a sticky deadlock after DEADLOCK_LIMIT consecutive empty-guard cycles.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_RUN      | normal selection, one scan per cycle
//   ST_PAUSED   | io_hold high: outputs held, ptr/lfsr/stall/count frozen
//   ST_DEADLOCK | no rule enabled for DEADLOCK_LIMIT cycles; left only by reset
module rule_scheduler #(
  parameter int unsigned NUM_RULES      = 32,
  parameter int unsigned DEADLOCK_LIMIT = 16,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  localparam int unsigned IDX_W         = $clog2(NUM_RULES)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_RULES-1:0] io_guard,
  input  logic                 io_mode,
  input  logic                 io_hold,
  output logic [IDX_W-1:0]     io_en_a,
  output logic                 io_fire,
  output logic                 io_deadlock,
  output logic [31:0]          io_fire_count
);

  localparam int unsigned STALL_W = $clog2(DEADLOCK_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_PAUSED   = 2'd1,
    ST_DEADLOCK = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [STALL_W-1:0]   stall_q, stall_d;
  logic [IDX_W-1:0]     en_a_q, en_a_d;
  logic                 fire_q, fire_d;
  logic                 deadlock_q, deadlock_d;
  logic [31:0]          count_q, count_d;

  logic [IDX_W-1:0]     rr_start;
  logic [IDX_W-1:0]     rnd_start;
  logic [IDX_W-1:0]     start;
  logic [IDX_W-1:0]     pick;
  logic                 found;
  logic [15:0]          lfsr_next;
  logic [STALL_W-1:0]   stall_inc;
  int                   idx;

  // Start point for this cycle's scan and first enabled rule at or after it (wrapping).
  always_comb begin
    rr_start = (int'(ptr_q) == int'(NUM_RULES) - 1) ? '0 : ptr_q + IDX_W'(1);
    rnd_start = lfsr_q[IDX_W-1:0];
    if (int'(rnd_start) >= int'(NUM_RULES)) begin
      rnd_start = rnd_start - IDX_W'(NUM_RULES);
    end
    start = io_mode ? rnd_start : rr_start;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < int'(NUM_RULES); i++) begin
      idx = int'(start) + i;
      if (idx >= int'(NUM_RULES)) begin
        idx = idx - int'(NUM_RULES);
      end
      if (!found && io_guard[idx[IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[IDX_W-1:0];
      end
    end
  end

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0.
  always_comb begin
    lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    stall_inc = stall_q + STALL_W'(1);
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lfsr_d     = lfsr_q;
    stall_d    = stall_q;
    en_a_d     = en_a_q;
    fire_d     = 1'b0;
    deadlock_d = deadlock_q;
    count_d    = count_q;
    case (state_q)
      ST_DEADLOCK: begin
        deadlock_d = 1'b1;
      end
      default: begin
        if (io_hold) begin
          state_d = ST_PAUSED;
        end else begin
          state_d = ST_RUN;
          lfsr_d  = lfsr_next;
          if (found) begin
            en_a_d  = pick;
            fire_d  = 1'b1;
            stall_d = '0;
            count_d = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;
            if (!io_mode) begin
              ptr_d = pick;
            end
          end else begin
            stall_d = stall_inc;
            if (stall_inc == STALL_W'(DEADLOCK_LIMIT)) begin
              state_d    = ST_DEADLOCK;
              deadlock_d = 1'b1;
            end
          end
        end
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_RUN;
      ptr_q      <= IDX_W'(NUM_RULES - 1);
      lfsr_q     <= LFSR_SEED;
      stall_q    <= '0;
      en_a_q     <= '0;
      fire_q     <= 1'b0;
      deadlock_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lfsr_q     <= lfsr_d;
      stall_q    <= stall_d;
      en_a_q     <= en_a_d;
      fire_q     <= fire_d;
      deadlock_q <= deadlock_d;
      count_q    <= count_d;
    end
  end

  assign io_en_a       = en_a_q;
  assign io_fire       = fire_q;
  assign io_deadlock   = deadlock_q;
  assign io_fire_count = count_q;

endmodule

// File: tb/tb_rule_scheduler.sv
// Bench for rule_scheduler: directed scenarios plus random traffic, with a
// queue-based scoreboard fed by a behavioural model of the scheduling rules.
module tb_rule_scheduler;

  localparam int NUM   = 32;
  localparam int LIMIT = 16;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] io_guard = '0;
  logic        io_mode = 1'b0;
  logic        io_hold = 1'b0;
  logic [4:0]  io_en_a;
  logic        io_fire;
  logic        io_deadlock;
  logic [31:0] io_fire_count;

  rule_scheduler #(
    .NUM_RULES      (NUM),
    .DEADLOCK_LIMIT (LIMIT),
    .LFSR_SEED      (SEED)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .io_guard      (io_guard),
    .io_mode       (io_mode),
    .io_hold       (io_hold),
    .io_en_a       (io_en_a),
    .io_fire       (io_fire),
    .io_deadlock   (io_deadlock),
    .io_fire_count (io_fire_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          step;
    logic [4:0]  en;
    logic        fire;
    logic        dl;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   step_no = 0;

  // reference model state
  int          m_ptr;
  int          m_lfsr;
  int          m_stall;
  int          m_en;
  bit          m_fire;
  bit          m_dl;
  longint      m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_step(input logic [31:0] g, input bit mode, input bit hold, input bit rst);
    int start;
    int k;
    bit found;
    int fb;
    if (rst) begin
      m_ptr = NUM - 1; m_lfsr = SEED; m_stall = 0;
      m_en = 0; m_fire = 0; m_dl = 0; m_cnt = 0;
      return;
    end
    m_fire = 0;
    if (m_dl || hold) return;
    if (mode) begin
      start = m_lfsr % NUM;
    end else begin
      start = (m_ptr + 1) % NUM;
    end
    found = 0;
    k = 0;
    for (int i = 0; i < NUM; i++) begin
      int j = (start + i) % NUM;
      if (!found && g[j]) begin
        found = 1;
        k = j;
      end
    end
    if (found) begin
      m_en = k;
      m_fire = 1;
      m_stall = 0;
      if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (!mode) m_ptr = k;
    end else begin
      m_stall = m_stall + 1;
      if (m_stall == LIMIT) m_dl = 1;
    end
    fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
    m_lfsr = ((m_lfsr * 2) + fb) % 65536;
  endtask

  task automatic drive(input logic [31:0] g, input bit mode, input bit hold, input bit rst);
    exp_t e;
    io_guard = g;
    io_mode  = mode;
    io_hold  = hold;
    reset    = rst;
    @(posedge clock);
    #1;
    model_step(g, mode, hold, rst);
    step_no++;
    e.step = step_no;
    e.en   = 5'(m_en);
    e.fire = m_fire;
    e.dl   = m_dl;
    e.cnt  = 32'(m_cnt);
    exp_q.push_back(e);
    @(negedge clock);
  endtask

  // Monitor: every cycle the DUT presents a fresh registered result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("sb_en_a[%0d]", e.step), 32'(io_en_a), 32'(e.en));
        chk($sformatf("sb_fire[%0d]", e.step), 32'(io_fire), 32'(e.fire));
        chk($sformatf("sb_deadlock[%0d]", e.step), 32'(io_deadlock), 32'(e.dl));
        chk($sformatf("sb_count[%0d]", e.step), io_fire_count, e.cnt);
      end
    end
  end

  initial begin
    logic [31:0] g;
    bit          mode;
    bit          hold;
    bit          rst;
    int          sel;

    drive('1, 0, 0, 1);
    drive('1, 0, 0, 1);
    chk("reset_en_a", 32'(io_en_a), 0);
    chk("reset_fire", 32'(io_fire), 0);
    chk("reset_count", io_fire_count, 0);

    // RR over all rules, wrapping past 31
    for (int i = 0; i < 34; i++) drive('1, 0, 0, 0);
    chk("rr_wrap_en_a", 32'(io_en_a), 1);
    chk("rr_count34", io_fire_count, 34);

    // two-rule alternation then single top rule
    for (int i = 0; i < 4; i++) drive(32'h0000_0110, 0, 0, 0);
    chk("rr_alt_en_a", 32'(io_en_a), 8);
    for (int i = 0; i < 3; i++) drive(32'h8000_0000, 0, 0, 0);
    chk("single_rule_en_a", 32'(io_en_a), 31);

    // one short of deadlock
    for (int i = 0; i < 15; i++) drive('0, 0, 0, 0);
    drive(32'h1, 0, 0, 0);
    chk("near_dl_flag", 32'(io_deadlock), 0);
    chk("near_dl_en_a", 32'(io_en_a), 0);

    // deadlock and its stickiness
    for (int i = 0; i < 16; i++) drive('0, 0, 0, 0);
    chk("dl_flag", 32'(io_deadlock), 1);
    for (int i = 0; i < 3; i++) drive('1, 0, i == 1, 0);
    chk("dl_no_fire", 32'(io_fire), 0);

    // random mode from the seed, with a hold window
    drive('1, 1, 0, 1);
    chk("rand_first_en_a", 32'(io_en_a), 0);
    drive('1, 1, 0, 0);
    chk("rand_seed_en_a", 32'(io_en_a), 32'(SEED[4:0]));
    for (int i = 0; i < 8; i++) drive('1, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive('1, 1, 1, 0);
    chk("hold_no_fire", 32'(io_fire), 0);
    for (int i = 0; i < 5; i++) drive('1, 1, 0, 0);
    for (int i = 0; i < 4; i++) drive('1, 0, 0, 0);

    // reset mid-RR restarts the sequence at rule 0
    drive('1, 0, 0, 1);
    drive('1, 0, 0, 0);
    chk("rr_restart_en_a", 32'(io_en_a), 0);
    drive('1, 0, 0, 0);

    // held empty-guard cycles do not count toward deadlock
    for (int i = 0; i < 10; i++) drive('0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive('0, 0, 1, 0);
    for (int i = 0; i < 5; i++) drive('0, 0, 0, 0);
    chk("hold_stall_no_dl", 32'(io_deadlock), 0);
    drive('0, 0, 0, 0);
    chk("hold_stall_dl", 32'(io_deadlock), 1);
    drive('1, 0, 0, 1);

    // random traffic
    mode = 0;
    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 2) g = '0;
      else if (sel < 5) g = 32'h1 << $urandom_range(0, 31);
      else if (sel < 7) g = $urandom & $urandom & $urandom;
      else g = $urandom;
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      hold = ($urandom_range(0, 9) == 0);
      rst  = ($urandom_range(0, 199) == 0) || (m_dl && $urandom_range(0, 3) == 0);
      drive(g, mode, hold, rst);
    end

    @(negedge clock);
    @(negedge clock);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
